// File: rtl/horn_arbiter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : horn_arbiter_sequencer
// Brief    : Shares the horn relay between alarm siren, fob panic and
//            lock/unlock chirps with fixed priority and timed patterns.
// Revision : 1.0 - initial release
// ============================================================================
module horn_arbiter_sequencer #(
    parameter int T_CHIRP_ON   = 2,
    parameter int T_CHIRP_GAP  = 2,
    parameter int T_PANIC_HALF = 4,
    parameter int T_PANIC_MAX  = 30,
    parameter int CW           = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ignition_switch,
    input  logic       alarm_siren,
    input  logic       panic_btn,
    input  logic       lock_req,
    input  logic       unlock_req,
    output logic       horn,
    output logic [1:0] src,
    output logic       busy,
    output logic       panic_active
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ALARM     = 3'd1,
        S_PANIC     = 3'd2,
        S_CHIRP_ON  = 3'd3,
        S_CHIRP_GAP = 3'd4
    } state_t;

    localparam logic [CW-1:0] c_on_last    = CW'(T_CHIRP_ON - 1);
    localparam logic [CW-1:0] c_gap_last   = CW'(T_CHIRP_GAP - 1);
    localparam logic [CW-1:0] c_half_last  = CW'(T_PANIC_HALF - 1);
    localparam logic [CW-1:0] c_panic_last = CW'(T_PANIC_MAX - 1);
    localparam logic [CW-1:0] c_timer_max  = '1;
    localparam logic [1:0]    c_src_idle   = 2'd0;
    localparam logic [1:0]    c_src_alarm  = 2'd1;
    localparam logic [1:0]    c_src_panic  = 2'd2;
    localparam logic [1:0]    c_src_chirp  = 2'd3;

    state_t        r_state;
    logic          r_horn;
    logic [1:0]    r_src;
    logic          r_panic_latch;
    logic [1:0]    r_chirp_pending;
    logic [1:0]    r_chirps_left;
    logic [CW-1:0] r_timer;
    logic [CW-1:0] r_half_cnt;

    logic          w_latch_next;
    logic          w_chirp_req;
    logic [1:0]    w_chirp_val;
    logic [CW-1:0] w_timer_inc;

    assign w_latch_next = r_panic_latch ^ panic_btn;
    assign w_chirp_req  = lock_req | unlock_req;
    assign w_chirp_val  = unlock_req ? 2'd2 : 2'd1;
    assign w_timer_inc  = (r_timer == c_timer_max) ? r_timer : r_timer + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_horn          <= 1'b0;
            r_src           <= c_src_idle;
            r_panic_latch   <= 1'b0;
            r_chirp_pending <= 2'd0;
            r_chirps_left   <= 2'd0;
            r_timer         <= '0;
            r_half_cnt      <= '0;
        end else if (alarm_siren) begin
            // Alarm wins from any state and flushes every queued request.
            r_state         <= S_ALARM;
            r_horn          <= 1'b1;
            r_src           <= c_src_alarm;
            r_panic_latch   <= 1'b0;
            r_chirp_pending <= 2'd0;
            r_chirps_left   <= 2'd0;
            r_timer         <= '0;
            r_half_cnt      <= '0;
        end else if (r_state == S_ALARM) begin
            r_state <= S_IDLE;
            r_horn  <= 1'b0;
            r_src   <= c_src_idle;
        end else if (ignition_switch) begin
            r_state         <= S_IDLE;
            r_horn          <= 1'b0;
            r_src           <= c_src_idle;
            r_panic_latch   <= 1'b0;
            r_chirp_pending <= 2'd0;
            r_chirps_left   <= 2'd0;
            r_timer         <= '0;
        end else begin
            r_panic_latch <= w_latch_next;
            if (w_chirp_req && r_state != S_PANIC)
                r_chirp_pending <= w_chirp_val;

            case (r_state)
                S_IDLE: begin
                    if (r_panic_latch) begin
                        r_state    <= S_PANIC;
                        r_horn     <= 1'b1;
                        r_src      <= c_src_panic;
                        r_timer    <= '0;
                        r_half_cnt <= '0;
                    end else if (r_chirp_pending != 2'd0) begin
                        r_state       <= S_CHIRP_ON;
                        r_horn        <= 1'b1;
                        r_src         <= c_src_chirp;
                        r_chirps_left <= r_chirp_pending;
                        r_timer       <= '0;
                        // A request on this very edge becomes the next pending count.
                        if (!w_chirp_req)
                            r_chirp_pending <= 2'd0;
                    end
                end
                S_PANIC: begin
                    if (!w_latch_next || r_timer == c_panic_last) begin
                        r_state       <= S_IDLE;
                        r_horn        <= 1'b0;
                        r_src         <= c_src_idle;
                        r_panic_latch <= 1'b0;
                        r_timer       <= '0;
                    end else begin
                        r_timer <= w_timer_inc;
                        if (r_half_cnt == c_half_last) begin
                            r_half_cnt <= '0;
                            r_horn     <= ~r_horn;
                        end else begin
                            r_half_cnt <= r_half_cnt + CW'(1);
                        end
                    end
                end
                S_CHIRP_ON: begin
                    if (r_timer == c_on_last) begin
                        r_state       <= S_CHIRP_GAP;
                        r_horn        <= 1'b0;
                        r_chirps_left <= r_chirps_left - 2'd1;
                        r_timer       <= '0;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                S_CHIRP_GAP: begin
                    if (r_timer == c_gap_last) begin
                        r_timer <= '0;
                        if (r_chirps_left != 2'd0) begin
                            r_state <= S_CHIRP_ON;
                            r_horn  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_src   <= c_src_idle;
                        end
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_horn  <= 1'b0;
                    r_src   <= c_src_idle;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign horn         = r_horn;
    assign src          = r_src;
    assign busy         = (r_state != S_IDLE);
    assign panic_active = (r_state == S_PANIC);

endmodule
`default_nettype wire

// File: tb/tb_horn_arbiter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_horn_arbiter_sequencer
// Brief    : Directed and random stimulus checked against a pattern-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_horn_arbiter_sequencer;

    localparam int T_CHIRP_ON   = 2;
    localparam int T_CHIRP_GAP  = 2;
    localparam int T_PANIC_HALF = 4;
    localparam int T_PANIC_MAX  = 30;
    localparam int CW           = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       ignition_switch;
    logic       alarm_siren;
    logic       panic_btn;
    logic       lock_req;
    logic       unlock_req;
    logic       horn;
    logic [1:0] src;
    logic       busy;
    logic       panic_active;

    int checks = 0;
    int errors = 0;

    // Reference model: owner, horn, latched requests, panic time, chirp horn queue.
    int m_src;
    bit m_horn;
    bit m_latch;
    int m_pend;
    int m_t;
    bit m_q[$];

    horn_arbiter_sequencer #(
        .T_CHIRP_ON  (T_CHIRP_ON),
        .T_CHIRP_GAP (T_CHIRP_GAP),
        .T_PANIC_HALF(T_PANIC_HALF),
        .T_PANIC_MAX (T_PANIC_MAX),
        .CW          (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ignition_switch(ignition_switch),
        .alarm_siren    (alarm_siren),
        .panic_btn      (panic_btn),
        .lock_req       (lock_req),
        .unlock_req     (unlock_req),
        .horn           (horn),
        .src            (src),
        .busy           (busy),
        .panic_active   (panic_active)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_src = 0; m_horn = 0; m_latch = 0; m_pend = 0; m_t = 0;
        m_q.delete();
    endfunction

    function automatic void model_step(input bit a, input bit ig, input bit pb,
                                       input bit lk, input bit ul);
        bit nl = m_latch;
        int np = m_pend;
        if (a) begin
            m_src = 1; m_horn = 1; nl = 0; np = 0; m_q.delete();
        end else if (m_src == 1) begin
            m_src = 0; m_horn = 0;
        end else if (ig) begin
            m_src = 0; m_horn = 0; nl = 0; np = 0; m_q.delete();
        end else begin
            nl = m_latch ^ pb;
            if (m_src != 2) begin
                if (ul) np = 2;
                else if (lk) np = 1;
            end
            case (m_src)
                0: begin
                    if (m_latch) begin
                        m_src = 2; m_t = 0; m_horn = 1;
                    end else if (m_pend != 0) begin
                        for (int c = 0; c < m_pend; c++) begin
                            for (int i = 0; i < T_CHIRP_ON; i++)  m_q.push_back(1'b1);
                            for (int i = 0; i < T_CHIRP_GAP; i++) m_q.push_back(1'b0);
                        end
                        m_src = 3;
                        m_horn = m_q.pop_front();
                        if (!(ul || lk)) np = 0;
                    end
                end
                2: begin
                    if (!nl || m_t == T_PANIC_MAX - 1) begin
                        m_src = 0; m_horn = 0; nl = 0;
                    end else begin
                        m_t++;
                        m_horn = ((m_t / T_PANIC_HALF) % 2 == 0);
                    end
                end
                default: begin
                    if (m_q.size() == 0) begin
                        m_src = 0; m_horn = 0;
                    end else begin
                        m_horn = m_q.pop_front();
                    end
                end
            endcase
        end
        m_latch = nl;
        m_pend  = np;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("horn", 32'(horn), 32'(m_horn));
        check("src", 32'(src), 32'(m_src));
        check("busy", 32'(busy), 32'(m_src != 0));
        check("panic_active", 32'(panic_active), 32'(m_src == 2));
    endtask

    task automatic step(input bit a, input bit ig, input bit pb, input bit lk, input bit ul);
        alarm_siren = a; ignition_switch = ig; panic_btn = pb; lock_req = lk; unlock_req = ul;
        @(posedge clk);
        model_step(a, ig, pb, lk, ul);
        #1;
        compare_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        int   n;
        logic [31:0] pat;
        bit   ign, alm;

        rst = 1'b1;
        ignition_switch = 0; alarm_siren = 0; panic_btn = 0; lock_req = 0; unlock_req = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Lock: one chirp then idle
        step(0, 0, 0, 1, 0);
        pat = '0;
        for (int i = 0; i < 5; i++) begin step(0, 0, 0, 0, 0); pat = {pat[30:0], horn}; end
        check("lock_pattern", pat, 32'b11000);
        idle_steps(2);

        // Unlock: two chirps, busy for exactly 8 cycles
        step(0, 0, 0, 0, 1);
        n = 0; pat = '0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0);
            if (busy) begin n++; pat = {pat[30:0], horn}; end
        end
        check("unlock_busy_cycles", 32'(n), 32'd8);
        check("unlock_pattern", pat, 32'b11001100);

        // Panic runs to its timeout
        step(0, 0, 1, 0, 0);
        n = 0; pat = '0;
        for (int i = 0; i < 34; i++) begin
            step(0, 0, 0, 0, 0);
            if (panic_active) begin
                if (n < 8) pat = {pat[30:0], horn};
                n++;
            end
        end
        check("panic_cycles", 32'(n), 32'd30);
        check("panic_pattern", pat, 32'b11110000);

        // Alarm preempts an unlock sequence; no chirp replay afterwards
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("alarm_src", 32'(src), 32'd1);
        check("alarm_horn", 32'(horn), 32'd1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin step(0, 0, 0, 0, 0); if (busy) n++; end
        check("alarm_no_replay", 32'(n), 32'd0);

        // Panic press with ignition on is ignored
        step(0, 1, 1, 0, 0);
        n = 0;
        for (int i = 0; i < 4; i++) begin step(0, 1, 0, 0, 0); if (busy) n++; end
        step(0, 0, 0, 0, 0);
        if (busy) n++;
        check("ign_panic_ignored", 32'(n), 32'd0);

        // Ignition aborts panic on the next edge
        step(0, 0, 1, 0, 0);
        idle_steps(3);
        step(0, 1, 0, 0, 0);
        check("ign_abort_src", 32'(src), 32'd0);
        check("ign_abort_horn", 32'(horn), 32'd0);
        idle_steps(2);

        // Lock and unlock together give two chirps
        step(0, 0, 0, 1, 1);
        n = 0;
        for (int i = 0; i < 10; i++) begin step(0, 0, 0, 0, 0); if (busy) n++; end
        check("lock_unlock_busy", 32'(n), 32'd8);

        // Asynchronous reset in the middle of panic
        step(0, 0, 1, 0, 0);
        idle_steps(2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("reset_mid_panic_horn", 32'(horn), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 1, 0);
        n = 0;
        for (int i = 0; i < 8; i++) begin step(0, 0, 0, 0, 0); if (busy) n++; end
        check("post_reset_single_chirp", 32'(n), 32'd4);

        // Random traffic against the model
        ign = 0; alm = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) ign = ~ign;
            if ($urandom_range(0, 24) == 0) alm = ~alm;
            step(alm, ign,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/horn_arbiter_sequencer.md
Name: horn_arbiter_sequencer

Overview:
- Owns the single horn/siren driver and shares it between four requesters:
  - alarm FSM siren (level request)
  - remote panic button (toggle)
  - remote lock chirp (one chirp)
  - remote unlock chirp (two chirps)
- Fixed priority: alarm > panic > chirp.
- Sequences timed horn patterns and sits between the alarm FSM / key-fob receiver and the horn relay output.

Parameters:
- T_CHIRP_ON, 2, cycles horn is on per chirp
- T_CHIRP_GAP, 2, cycles horn is off after each chirp
- T_PANIC_HALF, 4, half-period of panic horn pulsing in cycles
- T_PANIC_MAX, 30, max cycles in PANIC before auto-cancel
- CW, 5, width of internal timers; must hold T_PANIC_MAX

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- ignition_switch  input  1  1 = ignition on
- alarm_siren  input  1  level siren request from alarm FSM
- panic_btn  input  1  one-cycle pulse, fob panic press
- lock_req  input  1  one-cycle pulse, fob lock
- unlock_req  input  1  one-cycle pulse, fob unlock
- horn  output  1  horn relay drive, registered
- src  output  2  current owner: 0 idle, 1 alarm, 2 panic, 3 chirp; registered
- busy  output  1  1 when state != IDLE
- panic_active  output  1  1 when state == PANIC

Behaviour:
- Reset (asynchronous):
  - state = IDLE; horn, src, busy and panic_active = 0.
  - panic_latch = 0; chirp_pending = 0; chirps_left = 0; all timers = 0.
- Clocking and latency:
  - All inputs are sampled on the rising edge of clk.
  - State and outputs update on the same edge, with one cycle of latency from the request edge to horn.
- Request capture (only while ignition_switch = 0; ignored while ignition is on):
  - lock_req loads chirp_pending = 1.
  - unlock_req loads chirp_pending = 2.
  - Both in the same cycle: unlock wins (2).
  - A new request overwrites a pending count. It never alters a sequence already running.
  - panic_btn toggles panic_latch.
- ignition_switch = 1:
  - Clears panic_latch and chirp_pending.
  - Aborts PANIC and chirp states to IDLE on the next edge.
  - Does not block ALARM; alarm_siren alone governs ALARM.
- IDLE:
  - alarm_siren = 1 → ALARM.
  - Else panic_latch = 1 → PANIC (panic timer = 0).
  - Else chirp_pending != 0 → CHIRP_ON (chirps_left = pending, pending cleared, timer = 0).
  - Else stay in IDLE.
- ALARM:
  - horn = 1, src = 1.
  - Entering ALARM clears panic_latch, chirp_pending and chirps_left; requests arriving during ALARM are discarded.
  - alarm_siren = 0 → IDLE. Arbitration resumes the next cycle.
- PANIC:
  - src = 2. Panic timer t counts from 0 upward.
  - horn = 1 when floor(t / T_PANIC_HALF) is even, else 0. The first cycle in PANIC is horn high.
  - Exit to IDLE, clearing panic_latch, when either:
    - panic_latch is cleared by a second press or by ignition; or
    - t = T_PANIC_MAX-1.
  - alarm_siren = 1 → ALARM (preempts).
  - Chirp requests during PANIC are discarded.
- CHIRP_ON:
  - horn = 1, src = 3.
  - After T_CHIRP_ON cycles: decrement chirps_left, go to CHIRP_GAP.
- CHIRP_GAP:
  - horn = 0, src = 3.
  - After T_CHIRP_GAP cycles: chirps_left != 0 → CHIRP_ON, else → IDLE.
  - The trailing gap guarantees separation between back-to-back sequences.
- Chirp preemption:
  - alarm_siren = 1 in either chirp state → ALARM immediately, sequence discarded.
  - A panic press during a chirp sets panic_latch; PANIC is entered only after the sequence ends, via IDLE.
- Timers:
  - Unsigned CW bits, cleared on every state entry, saturating.
  - Never wrap.
- Outputs:
  - busy and panic_active are decoded from the registered state.
  - src = 0 exactly when the state is IDLE.

Test Plan:
- Reset mid-PANIC (rst pulsed while horn = 1) → same cycle: horn = 0, src = 0, busy = 0; later lock_req with no pending replay → single chirp only.
- Lock chirp: lock_req at edge N, ignition = 0 → horn = 1 for edges N+1..N+2, 0 for N+3..N+4, IDLE at N+5 (src 3 then 0).
- Unlock: unlock_req → horn pattern 1,1,0,0,1,1,0,0 then idle; busy high for exactly 8 cycles.
- Panic timeout: single panic_btn → horn 1111 0000 repeating, src = 2; returns to IDLE after exactly 30 cycles; panic_latch = 0.
- Alarm preempts chirp: unlock_req, then alarm_siren = 1 on the 2nd chirp-on cycle → next edge src = 1, horn = 1; drop alarm_siren → IDLE, no remaining chirp replayed.
- Ignition interactions:
  - panic_btn with ignition = 1 → no response.
  - Ignition raised during PANIC → IDLE next edge, horn = 0.
  - lock_req and unlock_req in the same cycle → 2 chirps.
